// File: rtl/card_dealer.sv
// card_dealer: deals single cards from a 52-card deck that is held as a
// table of per-rank counts. Each request walks a rank pointer to the next
// rank that is still in stock, then strobes that rank out for one cycle.
//
// Build option: define CARD_DEALER_SHUFFLE_EN to start each search at a
// pseudo-random rank taken from a 16-bit Galois LFSR. Without it, every
// search starts at the ace, so cards come out in ascending rank order.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dealRequest,
  input  logic       newDeck,
  output logic       addNewCard,
  output logic [3:0] newCardValue,
  output logic [5:0] cardsRemaining,
  output logic       deckEmpty,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } state_e;

  localparam int unsigned NUM_RANKS = 13;

  state_e     state_q;
  logic [2:0] count_q [NUM_RANKS];
  logic [3:0] ptr_q;
  logic [5:0] remaining_q;
  logic       add_q;
  logic [3:0] value_q;

  logic [3:0] ptr_load_d;
  logic [3:0] ptr_next_d;

  // A zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 16'h0000) begin : g_seed_check
    $error("card_dealer: LFSR_SEED must be non-zero");
  end

`ifdef CARD_DEALER_SHUFFLE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  lfsr_nib;

  // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form, mask 0xB400).
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  // Fold the low nibble into 0..12 so it is always a legal rank index.
  always_comb begin
    lfsr_nib   = lfsr_q[3:0];
    ptr_load_d = (lfsr_nib >= 4'd13) ? (lfsr_nib - 4'd13) : lfsr_nib;
  end

  // The LFSR free-runs; restocking the deck deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Deterministic build: every search starts at the ace.
  always_comb begin
    ptr_load_d = 4'd0;
  end
`endif

  // Rank pointer advance with wrap from king back to ace.
  always_comb begin
    ptr_next_d = (ptr_q == 4'd12) ? 4'd0 : (ptr_q + 4'd1);
  end

  // Dealer FSM: owns the deck table, the rank pointer and the card outputs.
  // NOTE: every register here is assigned with <= so all state moves together
  // at the edge; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 4'd0;
      remaining_q <= 6'd52;
      add_q       <= 1'b0;
      value_q     <= 4'd0;
      // NOTE: the count table is real deck state rather than scratch storage,
      // so it is reset entry by entry like any other register.
      for (int i = 0; i < NUM_RANKS; i++) begin
        count_q[i] <= 3'd4;
      end
    end else if (newDeck) begin
      // Restock wins over any request or deal in flight; the last dealt
      // value stays on newCardValue.
      state_q     <= IDLE;
      remaining_q <= 6'd52;
      add_q       <= 1'b0;
      for (int i = 0; i < NUM_RANKS; i++) begin
        count_q[i] <= 3'd4;
      end
    end else begin
      add_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dealRequest && !deckEmpty) begin
            ptr_q   <= ptr_load_d;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (count_q[ptr_q] != 3'd0) begin
            // Strobe and value are registered here so both appear in DEAL.
            state_q <= DEAL;
            add_q   <= 1'b1;
            value_q <= ptr_q + 4'd1;
          end else begin
            ptr_q <= ptr_next_d;
          end
        end
        DEAL: begin
          // The guard keeps the table and the total in step and stops any
          // underflow even if the table were somehow inconsistent.
          if (count_q[ptr_q] != 3'd0 && remaining_q != 6'd0) begin
            count_q[ptr_q] <= count_q[ptr_q] - 3'd1;
            remaining_q    <= remaining_q - 6'd1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addNewCard     = add_q;
  assign newCardValue   = value_q;
  assign cardsRemaining = remaining_q;
  assign deckEmpty      = (remaining_q == 6'd0);
  assign busy           = (state_q == SEARCH) || (state_q == DEAL);

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed and randomized dealing against a deck model that
// keeps one count per rank and a running total. In the default build the
// model predicts the exact rank (lowest rank still in stock) and the strobe
// latency; with CARD_DEALER_SHUFFLE_EN it checks that each dealt rank was
// still in stock, so two full passes prove every rank comes out four times.
module tb_card_dealer;

  logic       clk;
  logic       reset;
  logic       dealRequest;
  logic       newDeck;
  logic       addNewCard;
  logic [3:0] newCardValue;
  logic [5:0] cardsRemaining;
  logic       deckEmpty;
  logic       busy;

  int passed;
  int failed;
  int total;

  // Deck model.
  int cnt [13];
  int remaining;
  int last_val;

  card_dealer dut (
    .clk            (clk),
    .reset          (reset),
    .dealRequest    (dealRequest),
    .newDeck        (newDeck),
    .addNewCard     (addNewCard),
    .newCardValue   (newCardValue),
    .cardsRemaining (cardsRemaining),
    .deckEmpty      (deckEmpty),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int first_rank();
    for (int r = 0; r < 13; r++) begin
      if (cnt[r] > 0) return r;
    end
    return -1;
  endfunction

  task automatic model_restock();
    for (int r = 0; r < 13; r++) cnt[r] = 4;
    remaining = 52;
  endtask

  // One deal from an idle dealer. With hold_busy the request stays high
  // across the next edge too, while the dealer is busy, and must not queue.
  task automatic deal(input bit hold_busy);
    int k;
    int v;
    int exp_idx;
    bit seen;
    exp_idx = first_rank();
    @(negedge clk) dealRequest = 1'b1;
    @(negedge clk) dealRequest = hold_busy;
    check("busy_after_request", 16'(busy), 16'd1);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 20) begin
      if (addNewCard === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        dealRequest = 1'b0;
        k++;
      end
    end
    dealRequest = 1'b0;
    check("strobe_seen", 16'(seen), 16'd1);
    if (!seen) return;
    v = int'(newCardValue);
`ifdef CARD_DEALER_SHUFFLE_EN
    check("rank_in_stock", 16'((v >= 1 && v <= 13) ? (cnt[(v >= 1 && v <= 13) ? v - 1 : 0] > 0) : 1'b0), 16'd1);
    if (v < 1 || v > 13 || cnt[v - 1] == 0) return;
`else
    check("rank_value", 16'(v), 16'(exp_idx + 1));
    check("strobe_latency", 16'(k), 16'(exp_idx + 2));
    v = exp_idx + 1;
`endif
    cnt[v - 1]--;
    remaining--;
    last_val = v;
    @(negedge clk);
    check("strobe_width", 16'(addNewCard), 16'd0);
    check("cards_remaining", 16'(cardsRemaining), 16'(remaining));
    check("deck_empty", 16'(deckEmpty), 16'(remaining == 0));
    check("busy_after_deal", 16'(busy), 16'd0);
    check("value_held", 16'(newCardValue), 16'(last_val));
    if (hold_busy) begin
      repeat (3) begin
        @(negedge clk);
        check("no_queued_deal", 16'(addNewCard), 16'd0);
      end
      check("remaining_after_hold", 16'(cardsRemaining), 16'(remaining));
    end
  endtask

  task automatic restock();
    @(negedge clk) newDeck = 1'b1;
    @(negedge clk) newDeck = 1'b0;
    model_restock();
    check("restock_remaining", 16'(cardsRemaining), 16'd52);
    check("restock_not_empty", 16'(deckEmpty), 16'd0);
    check("restock_idle", 16'(busy), 16'd0);
    check("restock_value_kept", 16'(newCardValue), 16'(last_val));
  endtask

  // Request at edge N, restock at edge N+1: the pending deal must vanish.
  task automatic abort_deal();
    @(negedge clk) dealRequest = 1'b1;
    @(negedge clk) begin
      dealRequest = 1'b0;
      newDeck     = 1'b1;
    end
    @(negedge clk) newDeck = 1'b0;
    model_restock();
    check("abort_no_strobe", 16'(addNewCard), 16'd0);
    check("abort_idle", 16'(busy), 16'd0);
    check("abort_remaining", 16'(cardsRemaining), 16'd52);
    check("abort_value_kept", 16'(newCardValue), 16'(last_val));
    @(negedge clk);
    check("abort_no_late_strobe", 16'(addNewCard), 16'd0);
  endtask

  task automatic empty_request();
    check("empty_flag", 16'(deckEmpty), 16'd1);
    @(negedge clk) dealRequest = 1'b1;
    @(negedge clk) dealRequest = 1'b0;
    repeat (4) begin
      check("empty_no_strobe", 16'(addNewCard), 16'd0);
      check("empty_not_busy", 16'(busy), 16'd0);
      @(negedge clk);
    end
    check("empty_remaining", 16'(cardsRemaining), 16'd0);
  endtask

  initial begin
    int sel;
    bit seen;
    passed      = 0;
    failed      = 0;
    total       = 0;
    last_val    = 0;
    reset       = 1'b1;
    dealRequest = 1'b0;
    newDeck     = 1'b0;
    model_restock();

    // Reset state, with a request and a restock held alongside reset.
    repeat (2) @(negedge clk);
    dealRequest = 1'b1;
    newDeck     = 1'b1;
    @(negedge clk);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_strobe", 16'(addNewCard), 16'd0);
    dealRequest = 1'b0;
    newDeck     = 1'b0;
    @(negedge clk);
    check("reset_value", 16'(newCardValue), 16'd0);
    check("reset_remaining", 16'(cardsRemaining), 16'd52);
    check("reset_empty", 16'(deckEmpty), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Five spaced deals, then seven more (one with a held request), then the
    // thirteenth deal whose search has to skip the three exhausted ranks.
    repeat (5) begin
      deal(1'b0);
      repeat (2) @(negedge clk);
    end
    check("after_five_remaining", 16'(cardsRemaining), 16'(remaining));
    repeat (6) deal(1'b0);
    deal(1'b1);
    deal(1'b0);

    // Restock racing a fresh request.
    abort_deal();

    // Random mix of deals, restocks and aborts.
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 2) restock();
      else if (sel < 4) abort_deal();
      else if (remaining > 0) deal(1'($urandom_range(0, 1)));
      else empty_request();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Two full passes through the deck, each ending with a refused request.
    repeat (2) begin
      restock();
      repeat (52) deal(1'b0);
      empty_request();
    end

    // Reset landing in the DEAL cycle.
    restock();
    @(negedge clk) dealRequest = 1'b1;
    @(negedge clk) dealRequest = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (addNewCard === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("pre_reset_strobe", 16'(seen), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_deal_strobe", 16'(addNewCard), 16'd0);
    check("reset_in_deal_value", 16'(newCardValue), 16'd0);
    check("reset_in_deal_remaining", 16'(cardsRemaining), 16'd52);
    check("reset_in_deal_busy", 16'(busy), 16'd0);
    reset    = 1'b0;
    last_val = 0;
    model_restock();
    @(negedge clk);
    deal(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter: LFSR_SEED, 16'hACE1, non-zero reset value of the shuffle LFSR.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: dealRequest  input  1  request one card; sampled only in IDLE.
REQ-005 SHALL have port: newDeck  input  1  synchronous restock to a full 52-card deck.
REQ-006 SHALL have port: addNewCard  output  1  one-cycle strobe; newCardValue is valid in the same cycle (feeds handController addNewCard).
REQ-007 SHALL have port: newCardValue  output  4  dealt rank: 1=ace, 2..10, 11..13=J/Q/K; holds its last value between strobes.
REQ-008 SHALL have port: cardsRemaining  output  6  undealt cards in deck, 0..52.
REQ-009 SHALL have port: deckEmpty  output  1  high when cardsRemaining==0.
REQ-010 SHALL have port: busy  output  1  high in SEARCH and DEAL.

Function
REQ-011 SHALL keep a 13-entry table of per-rank counts, 3 bits each, range 0..4; the sum of all entries SHALL always equal cardsRemaining.
REQ-012 SHALL implement the states IDLE, SEARCH and DEAL.
REQ-013 IDLE: if dealRequest=1 and deckEmpty=0 at edge N, SHALL load rank pointer ptr (REQ-020/021) and enter SEARCH at N+1.
REQ-014 IDLE: if dealRequest=1 and deckEmpty=1, SHALL stay in IDLE with no strobe and no state change.
REQ-015 SEARCH: if count[ptr]>0, SHALL enter DEAL next cycle; else ptr SHALL advance to (ptr+1) mod 13.
REQ-016 Because cardsRemaining>0, SEARCH SHALL exit after at most 13 cycles.
REQ-017 DEAL: addNewCard SHALL be 1 for exactly this cycle.
REQ-018 DEAL: newCardValue SHALL equal ptr+1; count[ptr] and cardsRemaining SHALL each decrement by 1 at the end of the cycle; next state SHALL be IDLE.
REQ-019 Minimum latency SHALL be dealRequest sampled at edge N -> addNewCard high in cycle N+2; dealRequest while busy=1 SHALL be ignored, not queued.
REQ-020 (macro defined) ptr load SHALL be lfsr[3:0] mod 13.
REQ-021 (macro undefined) ptr load SHALL be 0, giving order A,A,A,A,2,2,2,2,...,K.
REQ-022 newDeck=1 SHALL, at the next edge, set all counts to 4, set cardsRemaining to 52 and set state to IDLE.
REQ-023 newDeck SHALL abort any SEARCH or DEAL in progress with no strobe in the following cycle.
REQ-024 newDeck SHALL take priority over dealRequest in the same cycle.
REQ-025 newDeck SHALL NOT alter the LFSR or newCardValue.
REQ-026 deckEmpty SHALL be combinational from cardsRemaining==0.
REQ-027 busy SHALL be a registered-state decode.
REQ-028 Counts SHALL never underflow below 0 or exceed 4.

Reset
REQ-029 reset=1 at an edge SHALL set state=IDLE, all counts=4, cardsRemaining=52, newCardValue=0, addNewCard=0, ptr=0 and lfsr=LFSR_SEED.
REQ-030 reset SHALL have priority over newDeck and dealRequest.
REQ-031 reset SHALL abort any in-flight deal with no strobe.
REQ-032 After reset, deckEmpty=0 and busy=0.

Configuration
REQ-033 Macro CARD_DEALER_SHUFFLE_EN: when defined, SHALL include a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) that advances every non-reset cycle; ptr loads per REQ-020.
REQ-034 When CARD_DEALER_SHUFFLE_EN is undefined, SHALL contain no LFSR logic; ptr loads per REQ-021, giving deterministic dealing for hand-level tests.
REQ-035 All other behaviour SHALL be identical in both builds.

Verification
REQ-036 Macro off, reset then 5 single dealRequest pulses spaced 4 cycles apart -> addNewCard strobes with newCardValue 1,1,1,1,2; cardsRemaining 47.
REQ-037 Macro off, reset then 52 deals -> each rank 1..13 dealt exactly 4 times in ascending order; deckEmpty=1 after the last strobe; a 53rd dealRequest -> no strobe, busy stays 0.
REQ-038 Macro off, deal 12 cards (ptr at rank 4) then request -> SEARCH spends 4 cycles (ptrs 0,1,2,3), strobe in cycle N+5 with value 4.
REQ-039 Request at edge N, newDeck=1 at edge N+1 -> no strobe at N+2; cardsRemaining=52; state IDLE.
REQ-040 Macro on, 52 deals then newDeck then 52 deals -> each pass yields every rank exactly 4 times; no strobe width >1 cycle; the sum of counts equals cardsRemaining every cycle.
REQ-041 reset asserted during DEAL cycle -> addNewCard=0 next cycle, newCardValue=0, cardsRemaining=52.
